pipeline_stall_controller: RTL and testbench

- Central pipeline-control block for the 5-stage RISC-V core, sitting downstream of the load-use hazard detector. It consumes that unit's stall request, plus the EX-stage branch-taken flush and the data-memory busy signal.
- Converts these into per-stage write enables and bubble/flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Tracks multi-cycle memory waits and a flush deferred across them with a small FSM.
- Keeps saturating performance counters and a memory-wait watchdog.

---
 rtl/pipeline_stall_controller.sv | 127 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Pipeline control for the 5-stage core: turns load-use stalls, EX branch flushes and
// data-memory waits into per-stage write/bubble controls, with perf counters and a wait watchdog.
module pipeline_stall_controller #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             stall_req,
    input  logic             branch_taken_ex,
    input  logic             dmem_busy,
    input  logic             clr_counters,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] mem_wait_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_WAIT_FP, FLUSH_DEF} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT);

    state_t          state_q, state_d;
    logic [TO_W-1:0] timer_q, timer_inc;
    logic            in_wait, do_freeze, do_flush, do_stall;

    assign in_wait   = (state_q == MEM_WAIT) || (state_q == MEM_WAIT_FP);
    assign do_freeze = dmem_busy;
    assign do_flush  = !dmem_busy && (branch_taken_ex || (state_q == FLUSH_DEF));
    assign do_stall  = !dmem_busy && !do_flush && stall_req;
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TO_ONE;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= RUN;
        else         state_q <= state_d;
    end

    // A flush owed by an earlier branch survives further busy cycles and is only
    // performed in FLUSH_DEF, the cycle after the wait has fully ended.
    always_comb begin
        state_d = RUN;
        if (dmem_busy) begin
            if (state_q == MEM_WAIT_FP || state_q == FLUSH_DEF || branch_taken_ex)
                state_d = MEM_WAIT_FP;
            else
                state_d = MEM_WAIT;
        end else if (state_q == MEM_WAIT_FP) begin
            state_d = FLUSH_DEF;
        end
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b1;
        mem_wb_bubble = 1'b0;
        if (!arst_n) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_write   = 1'b0;
            id_ex_bubble  = 1'b1;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (do_freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (do_flush) begin
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
        end else if (do_stall) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_bubble  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            timer_q <= '0;
        end else if (in_wait) begin
            timer_q <= timer_inc;
        end else begin
            timer_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cycles    <= '0;
            mem_wait_cycles <= '0;
            flush_count     <= '0;
            mem_timeout     <= 1'b0;
        end else if (clr_counters) begin
            stall_cycles    <= '0;
            mem_wait_cycles <= '0;
            flush_count     <= '0;
            mem_timeout     <= 1'b0;
        end else begin
            if (do_stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_ONE;
            if (do_freeze && mem_wait_cycles != '1)
                mem_wait_cycles <= mem_wait_cycles + CNT_ONE;
            if (do_flush && flush_count != '1)
                flush_count <= flush_count + CNT_ONE;
            if (in_wait && dmem_busy && timer_inc >= TO_LIM)
                mem_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: driver pushes expected controls/counters from a cycle-level model of
// the stall/flush/wait rules; a negedge monitor pops and compares against the DUT.
module tb_pipeline_stall_controller;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 3;
    localparam int CMAX    = 15;

    logic clk = 1'b0;
    logic arst_n, stall_req, branch_taken_ex, dmem_busy, clr_counters;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble;
    logic [CNT_W-1:0] stall_cycles, mem_wait_cycles, flush_count;
    logic mem_timeout;

    pipeline_stall_controller #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .arst_n(arst_n), .stall_req(stall_req), .branch_taken_ex(branch_taken_ex),
        .dmem_busy(dmem_busy), .clr_counters(clr_counters),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
        .mem_wb_bubble(mem_wb_bubble), .stall_cycles(stall_cycles),
        .mem_wait_cycles(mem_wait_cycles), .flush_count(flush_count), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] ctl;   // {pc, ifw, iff, idw, idb, exw, mwb}
        int         sc, mc, fc;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: what the pipeline is waiting on, not how the RTL encodes it.
    bit m_waiting, m_pending, m_due, m_to;
    int m_wait_len, m_sc, m_mc, m_fc;

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_clear();
        m_waiting = 0; m_pending = 0; m_due = 0; m_to = 0;
        m_wait_len = 0; m_sc = 0; m_mc = 0; m_fc = 0;
    endtask

    task automatic cyc(input bit rst, input bit s, input bit b, input bit m, input bit c);
        exp_t e;
        bit   flush;
        arst_n = !rst; stall_req = s; branch_taken_ex = b; dmem_busy = m; clr_counters = c;
        if (rst) begin
            model_clear();
            e.ctl = 7'b0010101; e.sc = 0; e.mc = 0; e.fc = 0; e.to = 1'b0;
        end else begin
            flush = !m && (b || m_due);
            e.sc = m_sc; e.mc = m_mc; e.fc = m_fc; e.to = m_to;
            if (m)          e.ctl = 7'b0000001;
            else if (flush) e.ctl = 7'b1111110;
            else if (s)     e.ctl = 7'b0001110;
            else            e.ctl = 7'b1101010;
            if (c) begin
                m_sc = 0; m_mc = 0; m_fc = 0; m_to = 0;
            end else begin
                if (m)               m_mc = sat_inc(m_mc);
                else if (flush)      m_fc = sat_inc(m_fc);
                else if (s)          m_sc = sat_inc(m_sc);
                if (m_waiting && m && (m_wait_len + 1 >= TIMEOUT)) m_to = 1;
            end
            m_wait_len = m_waiting ? m_wait_len + 1 : 0;
            if (m) begin
                m_pending = m_pending || m_due || b;
                m_due     = 0;
                m_waiting = 1;
            end else begin
                m_due     = m_pending;
                m_pending = 0;
                m_waiting = 0;
            end
        end
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [6:0] act;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble};
            n_vec++;
            if (act !== e.ctl || stall_cycles !== CNT_W'(e.sc) || mem_wait_cycles !== CNT_W'(e.mc) ||
                flush_count !== CNT_W'(e.fc) || mem_timeout !== e.to) begin
                n_bad++;
                $display("FAIL vec%0d @%0t: ctl=%b sc=%0d mc=%0d fc=%0d to=%b, required ctl=%b sc=%0d mc=%0d fc=%0d to=%b",
                         n_vec, $time, act, stall_cycles, mem_wait_cycles, flush_count, mem_timeout,
                         e.ctl, e.sc, e.mc, e.fc, e.to);
            end
        end
    end

    initial begin
        arst_n = 1'b0; stall_req = 1'b0; branch_taken_ex = 1'b0; dmem_busy = 1'b0; clr_counters = 1'b0;
        model_clear();
        @(posedge clk); #1;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0);
        // single load-use stall, then stall coinciding with a branch flush
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // three-cycle memory wait with a branch on the second cycle
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        // watchdog: busy held six cycles, sticky until cleared
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        // counter saturation and clear winning over an increment
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        // reset while a flush is pending must discard it
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) < 2),
                ($urandom_range(0, 99) < 35),
                ($urandom_range(0, 99) < 15),
                ($urandom_range(0, 99) < 30),
                ($urandom_range(0, 99) < 3));
        end
        // long random busy bursts to exercise the watchdog and deferred flush
        for (int i = 0; i < 200; i++) begin
            cyc(1'b0, ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 10),
                ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 2));
        end
        cyc(0, 0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
